// File: rtl/serial_loader_pkg.sv
// Shared types and constants for the serial word loader.
package loader_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/serial_loader_if.sv
// Control/serial/load bundle between a requester and serial_loader.
interface serial_loader_if import loader_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             Start;
  logic             Sel;
  logic             Ser_Valid;
  logic             Ser_In;
  logic [WIDTH-1:0] D;
  logic             Ld_A;
  logic             Ld_B;
  logic             Busy;
  logic             Err;

  modport master (
    output Start, Sel, Ser_Valid, Ser_In,
    input  D, Ld_A, Ld_B, Busy, Err
  );

  modport slave (
    input  Start, Sel, Ser_Valid, Ser_In,
    output D, Ld_A, Ld_B, Busy, Err
  );
endinterface

// File: rtl/serial_loader_shift_in_reg.sv
// LSB-first shift register with a saturating bit counter, synchronous clear and enable.
module shift_in_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (en_i) begin
      data_d = {bit_i, data_q[WIDTH-1:1]};
      // Counter sticks at the terminal count instead of wrapping.
      if (cnt_q != CNT_TERM) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/serial_loader.sv
// Receives one LSB-first word and strobes it into register A or B.
// Define SERIAL_LOADER_PARITY_EN to append and check an even-parity bit.
module serial_loader import loader_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           Clk,
  input  logic           Reset,
  serial_loader_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIAL_LOADER_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             clr, shift_en;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] cnt;
`ifdef SERIAL_LOADER_PARITY_EN
  logic             err_q, err_d;
`endif

  shift_in_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk    (Clk),
    .rst    (Reset),
    .clr_i  (clr),
    .en_i   (shift_en),
    .bit_i  (bus.Ser_In),
    .data_o (data),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    clr      = 1'b0;
    shift_en = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          sel_d   = bus.Sel;
          clr     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.Ser_Valid) begin
`ifdef SERIAL_LOADER_PARITY_EN
          if (cnt != CNT_TERM) begin
            shift_en = 1'b1;
          end else if ((^data ^ bus.Ser_In) == 1'b0) begin
            state_d = ST_LOAD;
          end else begin
            // Bad parity: report and skip the load entirely.
            err_d   = 1'b1;
            state_d = ST_HOLD;
          end
`else
          shift_en = 1'b1;
          if (cnt == CNT_LAST) state_d = ST_LOAD;
`endif
        end
      end
      ST_LOAD: state_d = ST_HOLD;
      ST_HOLD: begin
        // Wait for Start to drop so a held request cannot reload.
        if (!bus.Start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.D    = data;
  assign bus.Ld_A = (state_q == ST_LOAD) && !sel_q;
  assign bus.Ld_B = (state_q == ST_LOAD) &&  sel_q;
  assign bus.Busy = (state_q == ST_SHIFT) || (state_q == ST_LOAD);

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: expected loads queued at send time, checked on strobe.
module tb_serial_loader;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  serial_loader_if #(.WIDTH(WIDTH)) bus_if ();

  serial_loader #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  exp_t sb_q[$];
  int   n_chk   = 0;
  int   n_bad   = 0;
  int   lda_n   = 0;
  int   ldb_n   = 0;
  int   err_n   = 0;
  int   exp_lda = 0;
  int   exp_ldb = 0;
  int   exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Sends one word (plus parity bit when enabled); bad_par flips the parity bit.
  task automatic send_word(input logic [WIDTH-1:0] val, input logic sel,
                           input bit gaps, input bit keep_start, input bit bad_par);
    int   nbits;
    logic b;
    exp_t e;
    nbits = WIDTH;
`ifdef SERIAL_LOADER_PARITY_EN
    nbits = WIDTH + 1;
`endif
    if (!bad_par) begin
      e.sel  = sel;
      e.data = val;
      sb_q.push_back(e);
      if (sel) exp_ldb++; else exp_lda++;
    end else begin
      exp_err++;
    end
    bus_if.Start = 1'b1;
    bus_if.Sel   = sel;
    tick();
    if (!keep_start) bus_if.Start = 1'b0;
    bus_if.Sel = ~sel;
    chk("busy_after_start", 32'(bus_if.Busy), 1);
    for (int i = 0; i < nbits; i++) begin
      b = (i < WIDTH) ? val[i] : ((^val) ^ bad_par);
      bus_if.Ser_Valid = 1'b1;
      bus_if.Ser_In    = b;
      tick();
      bus_if.Ser_Valid = 1'b0;
      bus_if.Ser_In    = ~b;
      if (i < nbits - 1) begin
        chk("busy_rx", 32'(bus_if.Busy), 1);
        if (gaps) begin
          tick();
          chk("busy_gap", 32'(bus_if.Busy), 1);
        end
      end
    end
    if (bad_par) begin
      chk("err_pulse", 32'(bus_if.Err), 1);
      chk("err_no_ld", 32'(bus_if.Ld_A | bus_if.Ld_B), 0);
      chk("err_busy", 32'(bus_if.Busy), 0);
    end else begin
      chk("ld_strobe", 32'(sel ? bus_if.Ld_B : bus_if.Ld_A), 1);
      chk("ld_other", 32'(sel ? bus_if.Ld_A : bus_if.Ld_B), 0);
      chk("ld_busy", 32'(bus_if.Busy), 1);
    end
    tick();
    chk("hold_no_ld", 32'(bus_if.Ld_A | bus_if.Ld_B), 0);
    chk("hold_err_low", 32'(bus_if.Err), 0);
    chk("hold_busy", 32'(bus_if.Busy), 0);
    if (!bad_par) chk("hold_d", 32'(bus_if.D), 32'(val));
    if (!keep_start) tick();
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge Clk);
      if (!Reset) begin
        if (bus_if.Ld_A || bus_if.Ld_B) begin
          chk("ld_onehot", 32'(bus_if.Ld_A & bus_if.Ld_B), 0);
          if (bus_if.Ld_A) lda_n++;
          else             ldb_n++;
          if (sb_q.size() == 0) begin
            chk("ld_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_data", 32'(bus_if.D), 32'(e.data));
            chk("sb_sel", 32'(bus_if.Ld_B), 32'(e.sel));
          end
        end
        if (bus_if.Err) err_n++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.Start     = 1'b0;
    bus_if.Sel       = 1'b0;
    bus_if.Ser_Valid = 1'b0;
    bus_if.Ser_In    = 1'b0;
    Reset            = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_d", 32'(bus_if.D), 0);
    chk("rst_lda", 32'(bus_if.Ld_A), 0);
    chk("rst_ldb", 32'(bus_if.Ld_B), 0);
    chk("rst_busy", 32'(bus_if.Busy), 0);
    chk("rst_err", 32'(bus_if.Err), 0);
    Reset = 1'b0;
    tick();

    // Serial activity while idle must not disturb D.
    bus_if.Ser_Valid = 1'b1;
    bus_if.Ser_In    = 1'b1;
    repeat (3) tick();
    bus_if.Ser_Valid = 1'b0;
    chk("idle_ignore_d", 32'(bus_if.D), 0);
    chk("idle_ignore_busy", 32'(bus_if.Busy), 0);

    send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);

    // Start held through and after the load: no second strobe.
    send_word(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) tick();
    chk("held_busy", 32'(bus_if.Busy), 0);
    chk("held_lda_cnt", 32'(lda_n), 32'(exp_lda));
    bus_if.Start = 1'b0;
    tick();
    send_word(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a word.
    bus_if.Start = 1'b1;
    bus_if.Sel   = 1'b0;
    tick();
    bus_if.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.Ser_Valid = 1'b1;
      bus_if.Ser_In    = 1'b1;
      tick();
    end
    bus_if.Ser_Valid = 1'b0;
    chk("pre_rst_d", 32'(bus_if.D), 32'h0F0);
    Reset = 1'b1;
    #1;
    chk("mid_rst_d", 32'(bus_if.D), 0);
    chk("mid_rst_busy", 32'(bus_if.Busy), 0);
    chk("mid_rst_ld", 32'(bus_if.Ld_A | bus_if.Ld_B), 0);
    bus_if.Start     = 1'b1;
    bus_if.Ser_Valid = 1'b1;
    tick();
    chk("rst_dominates", 32'(bus_if.Busy), 0);
    bus_if.Start     = 1'b0;
    bus_if.Ser_Valid = 1'b0;
    Reset = 1'b0;
    tick();
    send_word(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_LOADER_PARITY_EN
    send_word(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 4; k++) begin
      send_word(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    repeat (3) tick();
    chk("cnt_lda", 32'(lda_n), 32'(exp_lda));
    chk("cnt_ldb", 32'(ldb_n), 32'(exp_ldb));
    chk("cnt_err", 32'(err_n), 32'(exp_err));
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter WIDTH, default 8: operand word width in bits; the block SHALL support any value from 4 to 16.
REQ-002 Port Clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port Reset, input, 1: asynchronous active-high reset.
REQ-004 Port Start, input, 1: synchronized, active-high request to begin receiving one word.
REQ-005 Port Sel, input, 1: target register; 0 = A, 1 = B; sampled only when Start is accepted.
REQ-006 Port Ser_Valid, input, 1: qualifies Ser_In for the current cycle.
REQ-007 Port Ser_In, input, 1: serial data bit, LSB first, matching register_unit shift-out order.
REQ-008 Port D, output, WIDTH: assembled word, driven to register_unit D.
REQ-009 Port Ld_A, output, 1: one-cycle load strobe for register A.
REQ-010 Port Ld_B, output, 1: one-cycle load strobe for register B.
REQ-011 Port Busy, output, 1: high while a word is being received or loaded.
REQ-012 Port Err, output, 1: one-cycle parity-error strobe; this port SHALL exist in both builds.

Function
REQ-013 The block SHALL have a Moore FSM with states IDLE, SHIFT, LOAD and HOLD; all outputs SHALL be registered or decoded from state only.
REQ-014 In IDLE, Start=1 at a clock edge SHALL latch Sel, clear the bit counter and D, and enter SHIFT on that edge; Ser_Valid SHALL be ignored in IDLE.
REQ-015 In SHIFT, each edge with Ser_Valid=1 SHALL perform D <= {Ser_In, D[WIDTH-1:1]} and increment the counter.
REQ-016 In SHIFT, an edge with Ser_Valid=0 SHALL leave D and the counter unchanged; gaps of any length SHALL be tolerated.
REQ-017 On the edge that samples the last data bit, the FSM SHALL enter LOAD, so the strobe appears in the cycle immediately after that edge.
REQ-018 In LOAD, exactly one of Ld_A or Ld_B (per latched Sel) SHALL be high for exactly one cycle, with D stable; the FSM SHALL then enter HOLD.
REQ-019 In HOLD, the FSM SHALL remain until Start=0, then return to IDLE; a Start held high SHALL never cause a second load.
REQ-020 Start deasserting during SHIFT SHALL be ignored, and reception SHALL continue.
REQ-021 Busy SHALL be 1 in SHIFT and LOAD, and 0 in IDLE and HOLD.
REQ-022 D SHALL hold its last assembled value in HOLD and IDLE until the next accepted Start.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap; it saturates at the terminal count.

Reset
REQ-024 Reset=1 SHALL asynchronously force state IDLE, D=0, counter=0, Ld_A=0, Ld_B=0, Busy=0 and Err=0, including mid-SHIFT and mid-LOAD.
REQ-025 Reset SHALL dominate Start and Ser_Valid on any edge.

Configuration
REQ-026 With SERIAL_LOADER_PARITY_EN defined, one extra valid bit SHALL follow the data bits, and even parity over data plus parity bit SHALL be checked.
REQ-027 In that build, a parity match SHALL proceed to LOAD; a mismatch SHALL skip LOAD, pulse Err for one cycle, and enter HOLD with no Ld strobe.
REQ-028 Without SERIAL_LOADER_PARITY_EN, exactly WIDTH bits SHALL be received and Err SHALL be constant 0.

Structure
REQ-029 Package loader_pkg SHALL hold the FSM state enum typedef and the default width constant of 8.
REQ-030 The datapath SHALL be one sub-module, shift_in_reg, holding the shift register and bit counter with enable and clear; serial_loader holds the FSM.

Verification
REQ-031 Reset asserted for 2 cycles -> D=0x00, Ld_A=0, Ld_B=0, Busy=0, Err=0.
REQ-032 Start with Sel=0, then 0xA5 LSB first on 8 consecutive valid cycles -> Ld_A pulses exactly once, the cycle after the 8th bit, with D=0xA5; Ld_B stays 0.
REQ-033 Start with Sel=1, then 0x3C with Ser_Valid low on alternate cycles -> a single Ld_B pulse with D=0x3C; Busy high throughout the reception.
REQ-034 Start held high for 20 cycles after a load -> no second strobe; release Start, reassert, send 0x0F -> a new load with D=0x0F.
REQ-035 Reset pulsed after 4 bits of 0xFF -> IDLE, D=0x00, no strobe; 0x12 sent afterwards -> loads correctly.
REQ-036 With SERIAL_LOADER_PARITY_EN, send 0x01 with parity bit 0 -> Err pulses once and no Ld; send 0x01 with parity bit 1 -> Ld_A pulses with D=0x01.
